// File: rtl/twiddle_fetch_ctrl.sv
// Read-side controller for a registered 1-cycle-latency twiddle ROM: issues a sequential
// address run, buffers returned words in a 2-entry FIFO and streams them over valid/ready.
module twiddle_fetch_ctrl #(
  parameter int NUM_TW    = 28,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] tw_data,
  output logic [ADDR_W-1:0] tw_index,
  output logic              tw_valid,
  input  logic              tw_ready,
  output logic              tw_last
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  NUM_TW_C   = CNT_W'(NUM_TW);
  localparam logic [CNT_W-1:0]  LAST_IDX_C = CNT_W'(NUM_TW - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE_C  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE_C = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] BASE_C     = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic               done_s;
  logic               issue_s;
  logic               pop_s;
  logic [CNT_W-1:0]   issued_r;
  logic [CNT_W-1:0]   popped_r;
  logic [ADDR_W-1:0]  next_addr_r;
  logic [ADDR_W-1:0]  last_addr_r;
  logic               inflight_r;
  logic [DATA_W-1:0]  mem_r [2];
  logic               wr_ptr_r;
  logic               rd_ptr_r;
  logic [1:0]         count_r;
  logic               busy_r;
  logic               done_r;

  assign tw_valid = (count_r != 2'd0);
  assign pop_s    = tw_valid & tw_ready;
  assign tw_data  = mem_r[rd_ptr_r];
  assign tw_index = popped_r[ADDR_W-1:0];
  assign tw_last  = tw_valid & (popped_r == LAST_IDX_C);
  assign busy     = busy_r;
  assign done     = done_r;

  // The ROM registers its address, so the word issued this cycle is pushed at the end of the
  // next one; crediting this cycle's pop keeps full throughput within two buffer entries.
  assign issue_s = (state_r == RUN) && (issued_r < NUM_TW_C) &&
                   (({1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s}) < 3'd2);

  // The address currently being issued, otherwise the last one issued (held between issues).
  assign rom_addr = issue_s ? next_addr_r : last_addr_r;

  // Next-state and done-pulse decode.
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (issue_s && (issued_r == LAST_IDX_C)) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (pop_s && tw_last) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
        done_s  = 1'b0;
      end
    endcase
  end

  // State, counters, address tracking and the 2-entry word buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      issued_r    <= {CNT_W{1'b0}};
      popped_r    <= {CNT_W{1'b0}};
      next_addr_r <= BASE_C;
      last_addr_r <= {ADDR_W{1'b0}};
      inflight_r  <= 1'b0;
      mem_r[0]    <= {DATA_W{1'b0}};
      mem_r[1]    <= {DATA_W{1'b0}};
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
      count_r     <= 2'd0;
    end else begin
      state_r    <= state_s;
      busy_r     <= (state_s != IDLE);
      done_r     <= done_s;
      inflight_r <= issue_s;

      if ((state_r == IDLE) && start) begin
        issued_r    <= {CNT_W{1'b0}};
        popped_r    <= {CNT_W{1'b0}};
        next_addr_r <= BASE_C;
      end else begin
        if (issue_s) begin
          issued_r    <= issued_r + CNT_ONE_C;
          next_addr_r <= next_addr_r + ADDR_ONE_C;
          last_addr_r <= next_addr_r;
        end
        if (pop_s) begin
          popped_r <= popped_r + CNT_ONE_C;
        end
      end

      if (inflight_r) begin
        mem_r[wr_ptr_r] <= rom_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end

      case ({inflight_r, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_fetch_ctrl.sv
// Directed bench for twiddle_fetch_ctrl: a 28-word run under several ready patterns,
// mid-run reset, ignored restart, and a single-word configuration at BASE_ADDR 9.
module tb_twiddle_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] tw_data;
  logic [4:0]  tw_index;
  logic        tw_valid;
  logic        tw_ready;
  logic        tw_last;

  logic        start1;
  logic        busy1;
  logic        done1;
  logic [4:0]  rom_addr1;
  logic [15:0] rom_data1;
  logic [15:0] tw_data1;
  logic [4:0]  tw_index1;
  logic        tw_valid1;
  logic        tw_ready1;
  logic        tw_last1;

  logic [15:0] rom_mem [32];

  int tests;
  int fails;

  twiddle_fetch_ctrl #(.NUM_TW(28), .BASE_ADDR(0), .ADDR_W(5), .DATA_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_data(rom_data), .tw_data(tw_data), .tw_index(tw_index),
    .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_last(tw_last)
  );

  twiddle_fetch_ctrl #(.NUM_TW(1), .BASE_ADDR(9), .ADDR_W(5), .DATA_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .tw_data(tw_data1), .tw_index(tw_index1),
    .tw_valid(tw_valid1), .tw_ready(tw_ready1), .tw_last(tw_last1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM models, one cycle of read latency.
  always @(posedge clk) begin
    rom_data  <= rom_mem[rom_addr];
    rom_data1 <= rom_mem[rom_addr1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always 1; mode 1: ready 1,0,0,1 repeating; mode 2: ready 0 for cycles 0-9.
  task automatic run(input int mode, input int start2, input int rst_at, input int ncyc,
                     output int words, output int dones, output int last_at, output int done_at);
    logic [15:0] pd;
    logic [4:0]  pi;
    logic        pstall;
    words = 0; dones = 0; last_at = -1; done_at = -1;
    pstall = 1'b0; pd = 16'h0000; pi = 5'd0;
    for (int c = 0; c < ncyc; c++) begin
      start = (c == 0) || (c == start2);
      rst   = (c == rst_at);
      case (mode)
        1:       tw_ready = ((c % 4) == 0) || ((c % 4) == 3);
        2:       tw_ready = (c >= 10);
        default: tw_ready = 1'b1;
      endcase
      #2;
      if (pstall) begin
        check("stall_data", tw_data, pd);
        check("stall_index", tw_index, pi);
      end
      if (mode == 0 && rst_at < 0) begin
        check("busy_window", busy, (c >= 1) && (c <= 30));
        check("valid_window", tw_valid, (c >= 3) && (c <= 30));
        if (c == 2) check("rom_addr_c2", rom_addr, 5'd1);
      end
      if (mode == 2 && c == 9) check("stall_rom_addr", rom_addr, 5'd1);
      if (rst_at >= 0 && c == rst_at + 1) begin
        check("rst_valid", tw_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rom_addr", rom_addr, 5'd0);
      end
      if (done) begin
        dones++;
        done_at = c;
      end
      if (tw_valid && tw_ready) begin
        check("word_data", tw_data, rom_mem[words]);
        check("word_index", tw_index, words);
        check("word_last", tw_last, words == 27);
        if (tw_last) last_at = c;
        words++;
      end
      pstall = tw_valid && !tw_ready;
      pd = tw_data;
      pi = tw_index;
      step();
    end
    start = 1'b0;
    rst = 1'b0;
    tw_ready = 1'b0;
  endtask

  initial begin
    int words, dones, last_at, done_at;
    tests = 0;
    fails = 0;
    for (int i = 0; i < 32; i++) rom_mem[i] = 16'h2000 + 16'(i * 17);
    rom_mem[0]  = 16'h0100;
    rom_mem[9]  = 16'h00B5;
    rom_mem[15] = 16'hFF13;
    rom_mem[27] = 16'hFFA9;

    rst = 1'b1; start = 1'b0; tw_ready = 1'b0; start1 = 1'b0; tw_ready1 = 1'b1;
    step();
    step();
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_valid", tw_valid, 1'b0);
    check("reset_rom_addr", rom_addr, 5'd0);
    check("reset_last", tw_last, 1'b0);
    check("reset_busy1", busy1, 1'b0);
    rst = 1'b0;
    step();

    // Full-rate run.
    run(0, -1, -1, 34, words, dones, last_at, done_at);
    check("full_words", words, 28);
    check("full_dones", dones, 1);
    check("full_last_cycle", last_at, 30);
    check("full_done_cycle", done_at, 31);
    step();

    // Ready toggling 1,0,0,1.
    run(1, -1, -1, 100, words, dones, last_at, done_at);
    check("toggle_words", words, 28);
    check("toggle_dones", dones, 1);
    step();

    // Ready held low for 10 cycles.
    run(2, -1, -1, 45, words, dones, last_at, done_at);
    check("stall_words", words, 28);
    check("stall_dones", dones, 1);
    check("stall_last_cycle", last_at, 37);
    check("stall_done_cycle", done_at, 38);
    step();

    // Second start during the run is ignored.
    run(0, 5, -1, 40, words, dones, last_at, done_at);
    check("restart_words", words, 28);
    check("restart_dones", dones, 1);
    check("restart_done_cycle", done_at, 31);
    step();

    // Reset in cycle 12, then a fresh run from index 0.
    run(0, -1, 12, 18, words, dones, last_at, done_at);
    check("rst_words", words, 10);
    check("rst_dones", dones, 0);
    run(0, -1, -1, 34, words, dones, last_at, done_at);
    check("after_rst_words", words, 28);
    check("after_rst_done_cycle", done_at, 31);
    step();

    // Single-word configuration at BASE_ADDR 9.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    #2;
    check("one_rom_addr", rom_addr1, 5'd9);
    check("one_busy", busy1, 1'b1);
    step();
    check("one_valid_c2", tw_valid1, 1'b0);
    step();
    check("one_valid_c3", tw_valid1, 1'b1);
    check("one_data", tw_data1, 16'h00B5);
    check("one_index", tw_index1, 5'd0);
    check("one_last", tw_last1, 1'b1);
    check("one_done_c3", done1, 1'b0);
    step();
    check("one_done_c4", done1, 1'b1);
    check("one_busy_c4", busy1, 1'b0);
    check("one_valid_c4", tw_valid1, 1'b0);
    step();
    check("one_done_c5", done1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/twiddle_fetch_ctrl.md
Name: twiddle_fetch_ctrl

Overview:
Read-side controller for the registered, 1-cycle-latency twiddle ROMs (5-bit address, 16-bit Q8.8 data). On a start pulse it issues a sequential address run to the ROM and captures the returned words in a 2-entry buffer. It delivers each word to the downstream butterfly over a valid/ready stream, tagging the last word, and sustains full throughput under backpressure.

Parameters:
NUM_TW, 28, number of twiddle words fetched per run (1..2^ADDR_W)
BASE_ADDR, 0, first ROM address of the run
ADDR_W, 5, ROM address width
DATA_W, 16, ROM data width (Q8.8 two's complement, passed through unmodified)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
start  in  1  run request, sampled only when idle
busy  out  1  run in progress
done  out  1  one-cycle pulse after final word accepted
rom_addr  out  ADDR_W  registered ROM address
rom_data  in  DATA_W  ROM output, valid the cycle after rom_addr is issued
tw_data  out  DATA_W  twiddle word to consumer
tw_index  out  ADDR_W  offset of tw_data within run (0..NUM_TW-1)
tw_valid  out  1  tw_data/tw_index/tw_last valid
tw_ready  in  1  consumer accepts when tw_valid&tw_ready
tw_last  out  1  high with the word at index NUM_TW-1

Behaviour:
- Reset (rst=1 at an edge): all outputs 0, rom_addr=0, FSM=IDLE, buffer empty, issue/return counters 0, in-flight flag cleared.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start=1: busy=1 the next cycle; start while busy is ignored.
  - RUN -> DRAIN when the last address (BASE_ADDR+NUM_TW-1) has been issued.
  - DRAIN -> IDLE when the word with tw_last is accepted: done=1 for exactly one cycle, busy=0 in the same cycle.
- Issue: an issue in cycle c drives rom_addr and sets the in-flight flag for cycle c+1; rom_data is captured into the buffer at the end of c+1.
- Issue rule: issue allowed iff issued<NUM_TW and (count + inflight - pop) < 2. pop = tw_valid&tw_ready this cycle.
- Buffer: 2-entry FIFO, never overflows by construction. tw_valid=(count>0). tw_data, tw_index and tw_last come from the head entry and are stable while tw_valid&!tw_ready.
- rom_addr increments by 1 per issue from BASE_ADDR, holds its value between issues, and wraps modulo 2^ADDR_W. No address beyond NUM_TW issues is generated.
- Latency, with start=1 in cycle 0 and tw_ready held 1:
  - rom_addr=BASE_ADDR in cycle 1
  - first tw_valid in cycle 3
  - one word per cycle thereafter
  - tw_last in cycle NUM_TW+2, done in cycle NUM_TW+3
- Backpressure: with tw_ready=0, at most 2 words are buffered and issue stalls. Once ready returns, the stream resumes with no word lost, duplicated or reordered.
- Simultaneous push and pop: count unchanged.
- Simultaneous start and rst: rst wins.
- rst mid-run: immediate return to IDLE, buffer flushed. rom_data returning the next cycle is discarded because the in-flight flag is cleared. done is not pulsed.
- NUM_TW=1: single word, tw_last=1 on it, done follows acceptance.

Test Plan:
- Real-part ROM model, BASE_ADDR=0, NUM_TW=28, tw_ready=1, start pulse in cycle 0 -> tw_valid from cycle 3; index 0=0x0100, 9=0x00B5, 15=0xFF13, 27=0xFFA9 with tw_last=1 in cycle 30; done=1 in cycle 31 only; busy high cycles 1-30.
- Same run with tw_ready toggling 1,0,0,1 repeatedly -> all 28 words delivered in order with correct values. The buffer never holds more than 2 words. tw_data is stable across every stall cycle.
- tw_ready=0 for 10 cycles from cycle 0, then 1 -> only addresses 0,1 are issued before the stall; rom_addr holds 1. Word 0=0x0100 appears at the first cycle ready returns, and the remaining words follow one per cycle.
- Second start pulse in cycle 5 of a run -> ignored. Exactly 28 words, one done pulse.
- rst asserted in cycle 12 -> cycle 13: tw_valid=0, busy=0, rom_addr=0, no done. A new start then reproduces the full sequence from index 0 (0x0100).
- NUM_TW=1, BASE_ADDR=9 -> single word 0x00B5 with tw_index=0 and tw_last=1, then a done pulse.
